ps2_rx_frontend: RTL and testbench

Serial front-end for the PS/2 keyboard path. It synchronises and deglitches the raw PS/2 clock and data lines, frames each 11-bit PS/2 packet (start, 8 data, parity, stop), and drives the downstream left-shift register with clear, enable and data strobes. It also reports frame completion and errors. It sits directly upstream of the 8-bit shift register that assembles the received byte for the scan-code decoder.

---
 rtl/ps2_rx_frontend_if.sv | 17 +
 rtl/ps2_rx_frontend.sv | 167 ++++++++++++++++
 tb/tb_ps2_rx_frontend.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_frontend_if.sv
// rtl/ps2_rx_frontend_if.sv - strobe/status bundle from the PS/2 receive front-end
interface ps2_rx_frontend_if;
  logic sclr;
  logic bit_en;
  logic bit_dat;
  logic frame_done;
  logic frame_err;
  logic busy;

  modport master (
    output sclr, bit_en, bit_dat, frame_done, frame_err, busy
  );

  modport slave (
    input sclr, bit_en, bit_dat, frame_done, frame_err, busy
  );
endinterface

// File: rtl/ps2_rx_frontend.sv
// rtl/ps2_rx_frontend.sv - PS/2 line sync/deglitch, 11-bit framing, shift-register strobes
// Optional parity checking enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_frontend #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_ps2_clk,
  input  logic               i_ps2_dat,
  ps2_rx_frontend_if.master  o_rx
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_filt;
  logic          r_filt_d;
  logic [FW-1:0] r_flt_cnt;
  logic          r_fall;
  logic          r_fall_dat;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic          r_par, w_par_nxt;
  logic          r_par_err, w_par_err_nxt;
  logic          r_err, w_err_nxt;
  logic [TW-1:0] r_to_cnt;
  logic          r_sclr, r_bit_en, r_bit_dat, r_done, r_busy;
  logic          w_sclr, w_bit_en, w_bit_dat, w_done;
  logic          w_timeout;

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_flt_cnt  <= '0;
      r_fall     <= 1'b0;
      r_fall_dat <= 1'b1;
    end else begin
      r_clk_s  <= {r_clk_s[0], i_ps2_clk};
      r_dat_s  <= {r_dat_s[0], i_ps2_dat};
      r_filt_d <= r_filt;
      if (r_clk_s[1] != r_filt) begin
        if (r_flt_cnt == FLT_MAX) begin
          r_filt    <= r_clk_s[1];
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FW'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
      r_fall     <= r_filt_d & ~r_filt;
      r_fall_dat <= r_dat_s[1];
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_nxt     = r_par;
    w_par_err_nxt = r_par_err;
    w_err_nxt     = r_err;
    w_sclr        = 1'b0;
    w_bit_en      = 1'b0;
    w_bit_dat     = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_fall && !r_fall_dat) begin
          w_sclr        = 1'b1;
          w_err_nxt     = 1'b0;
          w_bit_cnt_nxt = 3'd0;
          w_par_nxt     = 1'b0;
          w_par_err_nxt = 1'b0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (r_fall) begin
          w_bit_en      = 1'b1;
          w_bit_dat     = r_fall_dat;
          w_par_nxt     = r_par ^ r_fall_dat;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (r_fall) begin
          w_par_err_nxt = ~(r_par ^ r_fall_dat);
          w_state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (r_fall) begin
          w_done      = 1'b1;
          w_err_nxt   = ~r_fall_dat | (PAR_EN & r_par_err);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A falling edge in the same cycle takes priority over the timeout
    if (!r_fall && w_timeout) begin
      w_done      = 1'b1;
      w_err_nxt   = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_par     <= 1'b0;
      r_par_err <= 1'b0;
      r_err     <= 1'b0;
      r_to_cnt  <= '0;
      r_sclr    <= 1'b0;
      r_bit_en  <= 1'b0;
      r_bit_dat <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par     <= w_par_nxt;
      r_par_err <= w_par_err_nxt;
      r_err     <= w_err_nxt;
      r_sclr    <= w_sclr;
      r_bit_en  <= w_bit_en;
      r_bit_dat <= w_bit_dat;
      r_done    <= w_done;
      r_busy    <= (r_state != S_IDLE);
      if (r_state == S_IDLE || r_fall) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  assign o_rx.sclr       = r_sclr;
  assign o_rx.bit_en     = r_bit_en;
  assign o_rx.bit_dat    = r_bit_dat;
  assign o_rx.frame_done = r_done;
  assign o_rx.frame_err  = r_err;
  assign o_rx.busy       = r_busy;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// tb/tb_ps2_rx_frontend.sv - self-checking bench for ps2_rx_frontend
module tb_ps2_rx_frontend;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif
  localparam int FLT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ps2_clk;
  logic ps2_dat;
  always #5 clk = ~clk;

  ps2_rx_frontend_if rx_if ();

  ps2_rx_frontend #(.FILTER_LEN(FLT), .TIMEOUT(100)) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_ps2_clk (ps2_clk),
    .i_ps2_dat (ps2_dat),
    .o_rx      (rx_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_sclr, n_bit, n_done, n_overlap;
  int first_sclr_cyc, last_bit_cyc, done_cyc, t_start;
  logic [7:0] sh;
  logic [15:0] bitv;
  logic last_err, busy_after, want_busy, busy_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: downstream shift register plus event log, sampled on the falling clk edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.sclr && rx_if.bit_en) n_overlap++;
      if (want_busy) begin
        busy_after = rx_if.busy;
        want_busy = 1'b0;
      end
      if (rx_if.busy) busy_seen = 1'b1;
      if (rx_if.sclr) begin
        n_sclr++;
        sh = 8'h00;
        if (n_sclr == 1) first_sclr_cyc = cyc;
      end
      if (rx_if.bit_en) begin
        if (n_bit < 16) bitv[n_bit] = rx_if.bit_dat;
        n_bit++;
        sh = {sh[6:0], rx_if.bit_dat};
        last_bit_cyc = cyc;
      end
      if (rx_if.frame_done) begin
        n_done++;
        last_err = rx_if.frame_err;
        done_cyc = cyc;
        want_busy = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_sclr = 0; n_bit = 0; n_done = 0; n_overlap = 0;
    first_sclr_cyc = -1; last_bit_cyc = -1; done_cyc = -1;
    sh = 8'h00; bitv = 16'h0000; last_err = 1'bx;
    busy_after = 1'bx; want_busy = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      wait_n(10);
      ps2_clk = 1'b0;
      if (i == 0) t_start = cyc + 1;
      wait_n(20);
      ps2_clk = 1'b1;
      wait_n(10);
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  // Reference: error if stop is 0, or (when checked) data+parity do not XOR to 1
  function automatic logic model_err(input logic [7:0] b, input logic par, input logic stp);
    logic e;
    e = (stp == 1'b0);
    if (PAR_CHECK && ((^b ^ par) != 1'b1)) e = 1'b1;
    return e;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b, input logic par, input logic stp);
    check({tag, "_sclr"}, n_sclr, 1);
    check({tag, "_nbits"}, n_bit, 8);
    check({tag, "_bits"}, {24'h0, bitv[7:0]}, {24'h0, b});
    check({tag, "_reg"}, {24'h0, sh}, {24'h0, rev8(b)});
    check({tag, "_done"}, n_done, 1);
    check({tag, "_err"}, {31'h0, last_err}, {31'h0, model_err(b, par, stp)});
    check({tag, "_overlap"}, n_overlap, 0);
    check({tag, "_busy_after"}, {31'h0, busy_after}, 0);
  endtask

  logic [7:0] rb;
  logic rp, rs;

  initial begin
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    clear_mon();
    wait_n(3);
    check("reset_outputs", {26'h0, rx_if.sclr, rx_if.bit_en, rx_if.bit_dat,
          rx_if.frame_done, rx_if.frame_err, rx_if.busy}, 0);
    rst_n = 1'b1;
    wait_n(5);

    // Valid 0x1C frame, latency from first low sample to sclr
    clear_mon();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    wait_n(30);
    check_frame("f1c", 8'h1C, 1'b0, 1'b1);
    check("f1c_reg_const", {24'h0, sh}, 32'h38);
    check("latency", first_sclr_cyc - t_start, FLT + 3);

    // Parity flipped
    clear_mon();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    wait_n(30);
    check_frame("parflip", 8'h1C, 1'b1, 1'b1);

    // Bad stop bit, then a clean frame
    clear_mon();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    wait_n(30);
    check_frame("badstop", 8'h1C, 1'b0, 1'b0);
    check("badstop_idle", {31'h0, rx_if.busy}, 0);
    clear_mon();
    send_frame(8'h73, 1'b0, 1'b1, 11);
    wait_n(30);
    check_frame("after_badstop", 8'h73, 1'b0, 1'b1);

    // Timeout after 3 data bits
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b1, 4);
    wait_n(150);
    check("to_nbits", n_bit, 3);
    check("to_done", n_done, 1);
    check("to_err", {31'h0, last_err}, 1);
    check("to_delay", done_cyc - last_bit_cyc, 100);
    check("to_busy_after", {31'h0, busy_after}, 0);

    // Short glitches, then a falling edge with data high in IDLE
    clear_mon();
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      wait_n(2);
      ps2_clk = 1'b1;
      wait_n(8);
    end
    ps2_dat = 1'b1;
    wait_n(5);
    ps2_clk = 1'b0;
    wait_n(20);
    ps2_clk = 1'b1;
    wait_n(20);
    check("glitch_strobes", n_sclr + n_bit + n_done, 0);
    check("glitch_busy", {31'h0, busy_seen}, 0);

    // Reset after the 5th data bit
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b1, 6);
    check("rst_pre_busy", {31'h0, rx_if.busy}, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_outputs", {26'h0, rx_if.sclr, rx_if.bit_en, rx_if.bit_dat,
             rx_if.frame_done, rx_if.frame_err, rx_if.busy}, 0);
    wait_n(3);
    rst_n = 1'b1;
    wait_n(5);
    check("rst_no_done", n_done, 0);
    clear_mon();
    send_frame(8'hC3, 1'b1, 1'b1, 11);
    wait_n(30);
    check_frame("after_rst", 8'hC3, 1'b1, 1'b1);

    // Random frames: mostly valid parity and stop, some corrupted
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rp = ~(^rb) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 4) != 0);
      clear_mon();
      send_frame(rb, rp, rs, 11);
      wait_n(30);
      check_frame($sformatf("rand%0d", k), rb, rp, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
